// File: rtl/fft_uart_pkg.sv
// Shared definitions for the FFT UART links (receiver and transmitter).
//   UART_DATA_BITS : data bits per UART character (8N1 framing)
//   rx_state_e     : receive bit-FSM encoding, exported for debug/checkers
//   clks_per_bit() : clock cycles per bit for a given clock and baud rate
package fft_uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    RX_IDLE  = 3'd0,
    RX_START = 3'd1,
    RX_DATA  = 3'd2,
    RX_STOP  = 3'd3,
    RX_BREAK = 3'd4
  } rx_state_e;

  // Integer division; callers must keep the result at 4 or more so the
  // half-bit start sample lands strictly inside the start bit.
  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_rx_sample_loader_if.sv
// Sample stream from the UART receiver to the FFT input buffer.
//   data_o      : assembled sample word
//   valid_o     : data_o/last_o hold a word
//   ready_i     : consumer accepts the word
//   last_o      : word is the final sample of an FFT frame
//   frame_err_o : one-cycle pulse, bad stop bit seen
//   overrun_o   : one-cycle pulse, a completed word was dropped
// Handshake: a word transfers on every rising clk edge where valid_o and
// ready_i are both 1. While valid_o=1 and ready_i=0 the producer keeps
// data_o and last_o unchanged; valid_o never drops without a transfer
// (except on reset). ready_i may change freely.
interface uart_rx_sample_loader_if #(
  parameter int bit_width = 32
);
  logic [bit_width-1:0] data_o;
  logic                 valid_o;
  logic                 ready_i;
  logic                 last_o;
  logic                 frame_err_o;
  logic                 overrun_o;

  modport master (
    output data_o, valid_o, last_o, frame_err_o, overrun_o,
    input  ready_i
  );

  modport slave (
    input  data_o, valid_o, last_o, frame_err_o, overrun_o,
    output ready_i
  );
endinterface

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: 2-flop synchroniser plus bit FSM.
//   clk, rst_n    : clock, asynchronous active-low reset
//   rx_i          : raw UART line (idle high, asynchronous)
//   byte_o        : received byte, meaningful while byte_valid_o=1
//   byte_valid_o  : one-cycle strobe in the cycle the good stop bit is sampled
//   frame_err_o   : one-cycle strobe in the cycle a low stop bit is sampled
//   state_o       : current FSM state (debug)
module uart_rx_byte
  import fft_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      rx_i,
  output logic [UART_DATA_BITS-1:0] byte_o,
  output logic                      byte_valid_o,
  output logic                      frame_err_o,
  output rx_state_e                 state_o
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(UART_DATA_BITS);
  localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_BIT = IDX_W'(UART_DATA_BITS - 1);

  logic                      rx_meta, rx_s;
  rx_state_e                 state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;

  // Reset to the idle (high) level so reset release never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_i;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    shift_d      = shift_q;
    byte_valid_o = 1'b0;
    frame_err_o  = 1'b0;
    unique case (state_q)
      RX_IDLE: begin
        if (!rx_s) begin
          cnt_d   = '0;
          state_d = RX_START;
        end
      end
      RX_START: begin
        // Mid-bit check: a line already back high was only a glitch.
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rx_s ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[UART_DATA_BITS-1:1]};  // LSB arrives first
          if (idx_q == LAST_BIT) state_d = RX_STOP;
          else                   idx_d   = idx_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d = '0;
          if (rx_s) begin
            byte_valid_o = 1'b1;
            state_d      = RX_IDLE;
          end else begin
            frame_err_o = 1'b1;
            state_d     = RX_BREAK;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_BREAK: begin
        // Stay here until the line recovers so a stuck-low line is not a new start.
        if (rx_s) state_d = RX_IDLE;
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign byte_o  = shift_q;
  assign state_o = state_q;

endmodule

// File: rtl/uart_rx_sample_loader.sv
// UART receive path for the FFT: packs bit_width/8 bytes (little-endian)
// into sample words and presents them on a valid/ready stream, flagging
// the N-th word of each frame as last.
//   clk, rst_n     : clock, asynchronous active-low reset
//   rx_i           : UART line from the host
//   bus            : sample stream + error pulses (master side)
//   dbg_state      : receive bit-FSM state
//   dbg_sample_cnt : index of the next sample to be loaded within the frame
module uart_rx_sample_loader
  import fft_uart_pkg::*;
#(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD      = 115200,
  parameter int bit_width = 32,
  parameter int N         = 16,
  parameter int SIZE      = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      rx_i,
  uart_rx_sample_loader_if.master   bus,
  output rx_state_e                 dbg_state,
  output logic [SIZE-1:0]           dbg_sample_cnt
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
  localparam int BYTES        = bit_width / UART_DATA_BITS;
  localparam int BC_W         = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [BC_W-1:0] LAST_BYTE   = BC_W'(BYTES - 1);
  localparam logic [SIZE-1:0] LAST_SAMPLE = SIZE'(N - 1);

  logic [UART_DATA_BITS-1:0] rx_byte;
  logic                      rx_byte_valid, rx_frame_err;

  logic [bit_width-1:0] word_q, word_next;
  logic [BC_W-1:0]      byte_cnt_q;
  logic                 word_done;

  logic [bit_width-1:0] data_q;
  logic                 valid_q, last_q, frame_err_q, overrun_q;
  logic [SIZE-1:0]      sample_cnt_q;

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx_byte (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_i         (rx_i),
    .byte_o       (rx_byte),
    .byte_valid_o (rx_byte_valid),
    .frame_err_o  (rx_frame_err),
    .state_o      (dbg_state)
  );

  // Word with the incoming byte merged in; used both for accumulation and
  // to load the output register directly when the final byte arrives.
  always_comb begin
    word_next = word_q;
    for (int k = 0; k < BYTES; k++) begin
      if (byte_cnt_q == BC_W'(k)) word_next[k*UART_DATA_BITS +: UART_DATA_BITS] = rx_byte;
    end
  end

  assign word_done = rx_byte_valid && (byte_cnt_q == LAST_BYTE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q     <= '0;
      byte_cnt_q <= '0;
    end else if (rx_frame_err) begin
      byte_cnt_q <= '0;  // drop the partial word so the next byte starts a fresh one
    end else if (rx_byte_valid) begin
      word_q     <= word_next;
      byte_cnt_q <= word_done ? '0 : byte_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q       <= '0;
      valid_q      <= 1'b0;
      last_q       <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
      sample_cnt_q <= '0;
    end else begin
      frame_err_q <= rx_frame_err;
      overrun_q   <= 1'b0;
      if (word_done) begin
        if (!valid_q || bus.ready_i) begin
          data_q       <= word_next;
          valid_q      <= 1'b1;
          last_q       <= (sample_cnt_q == LAST_SAMPLE);
          sample_cnt_q <= (sample_cnt_q == LAST_SAMPLE) ? '0 : sample_cnt_q + 1'b1;
        end else begin
          overrun_q <= 1'b1;  // held word has priority; the new one is lost
        end
      end else if (valid_q && bus.ready_i) begin
        valid_q <= 1'b0;
        last_q  <= 1'b0;
      end
    end
  end

  assign bus.data_o      = data_q;
  assign bus.valid_o     = valid_q;
  assign bus.last_o      = last_q;
  assign bus.frame_err_o = frame_err_q;
  assign bus.overrun_o   = overrun_q;
  assign dbg_sample_cnt  = sample_cnt_q;

endmodule

// File: tb/tb_uart_rx_sample_loader.sv
module tb_uart_rx_sample_loader;
  import fft_uart_pkg::*;

  localparam int CLK_FREQ = 1_000_000;
  localparam int BAUD     = 100_000;
  localparam int CPB      = 10;
  localparam int W        = 32;
  localparam int N        = 16;
  localparam int SIZE     = 4;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic rx_i  = 1'b1;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_sample_loader_if #(.bit_width(W)) bus ();
  rx_state_e       dbg_state;
  logic [SIZE-1:0] dbg_sample_cnt;

  uart_rx_sample_loader #(
    .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .bit_width(W), .N(N), .SIZE(SIZE)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rx_i           (rx_i),
    .bus            (bus.master),
    .dbg_state      (dbg_state),
    .dbg_sample_cnt (dbg_sample_cnt)
  );

  // ---------------- scoreboard ----------------
  logic [W:0] exp_q[$];  // {last, data}
  int n_total = 0;
  int n_pass  = 0;
  int exp_cnt = 0;
  int fe_cnt  = 0;
  int ov_cnt  = 0;
  int hs_cnt  = 0;
  int unsigned rise_cyc = 0;
  logic prev_valid = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.valid_o && !prev_valid) rise_cyc = cyc;
      if (bus.frame_err_o) fe_cnt++;
      if (bus.overrun_o) ov_cnt++;
      if (bus.valid_o && bus.ready_i) begin
        hs_cnt++;
        check("word_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          logic [W:0] e;
          e = exp_q.pop_front();
          check("hs_data", bus.data_o, e[W-1:0]);
          check("hs_last", bus.last_o, e[W]);
        end
      end
    end
    prev_valid = bus.valid_o;
  end

  // ---------------- driver tasks ----------------
  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Leaves rx_i at the stop level so a low stop bit can be stretched by the caller.
  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx_i = 1'b0;
    wait_cycles(CPB);
    for (int i = 0; i < 8; i++) begin
      rx_i = b[i];
      wait_cycles(CPB);
    end
    rx_i = stop;
    wait_cycles(CPB);
  endtask

  task automatic send_word(input logic [W-1:0] w);
    for (int i = 0; i < W / 8; i++) send_byte(w[8*i +: 8], 1'b1);
  endtask

  task automatic expect_word(input logic [W-1:0] w);
    exp_q.push_back({(exp_cnt == N - 1), w});
    exp_cnt = (exp_cnt + 1) % N;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    rx_i  = 1'b1;
    wait_cycles(3);
    rst_n = 1'b1;
    exp_cnt = 0;
    wait_cycles(2);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int unsigned c0;
    int hs0;
    bus.ready_i = 1'b1;
    wait_cycles(3);

    // Reset values
    check("rst_data",  bus.data_o, 0);
    check("rst_valid", bus.valid_o, 0);
    check("rst_last",  bus.last_o, 0);
    check("rst_ferr",  bus.frame_err_o, 0);
    check("rst_ovr",   bus.overrun_o, 0);
    check("rst_state", dbg_state, RX_IDLE);
    check("rst_cnt",   dbg_sample_cnt, 0);
    rst_n = 1'b1;
    wait_cycles(2);

    // Basic word and valid timing
    hs0 = hs_cnt;
    expect_word(32'h1234_5678);
    send_byte(8'h78, 1'b1);
    send_byte(8'h56, 1'b1);
    send_byte(8'h34, 1'b1);
    c0 = cyc;
    send_byte(8'h12, 1'b1);
    wait_cycles(5);
    check("t1_rise_cycle", rise_cyc, c0 + 98);
    check("t1_words", hs_cnt - hs0, 1);

    // Frame of 16 words plus one to show last_o wrap
    do_reset();
    for (int i = 0; i < 17; i++) begin
      expect_word(32'hA000_0000 | i);
      send_word(32'hA000_0000 | i);
    end
    wait_cycles(5);
    check("t2_drained", exp_q.size(), 0);
    check("t2_cnt", dbg_sample_cnt, 1);

    // Glitch on idle line
    do_reset();
    fe_cnt = 0;
    hs0 = hs_cnt;
    rx_i = 1'b0;
    wait_cycles(3);
    rx_i = 1'b1;
    wait_cycles(20);
    check("t3_state", dbg_state, RX_IDLE);
    check("t3_no_word", hs_cnt - hs0, 0);
    check("t3_no_ferr", fe_cnt, 0);
    expect_word(32'hA5A5_A5A5);
    send_word(32'hA5A5_A5A5);
    wait_cycles(5);

    // Framing error, break hold, recovery
    do_reset();
    fe_cnt = 0;
    hs0 = hs_cnt;
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b0);
    wait_cycles(30);
    check("t4_break", dbg_state, RX_BREAK);
    check("t4_ferr_once", fe_cnt, 1);
    rx_i = 1'b1;
    wait_cycles(5);
    check("t4_idle", dbg_state, RX_IDLE);
    check("t4_no_word", hs_cnt - hs0, 0);
    expect_word(32'hDEAD_BEEF);
    send_word(32'hDEAD_BEEF);
    wait_cycles(5);

    // Back-pressure and overrun
    do_reset();
    bus.ready_i = 1'b0;
    ov_cnt = 0;
    hs0 = hs_cnt;
    send_word(32'h0403_0201);
    wait_cycles(5);
    check("t5_valid", bus.valid_o, 1);
    check("t5_data", bus.data_o, 32'h0403_0201);
    send_word(32'h0807_0605);
    wait_cycles(5);
    check("t5_held_data", bus.data_o, 32'h0403_0201);
    check("t5_held_last", bus.last_o, 0);
    check("t5_ovr_once", ov_cnt, 1);
    check("t5_cnt", dbg_sample_cnt, 1);
    expect_word(32'h0403_0201);
    bus.ready_i = 1'b1;
    wait_cycles(5);
    check("t5_valid_drop", bus.valid_o, 0);
    check("t5_one_word", hs_cnt - hs0, 1);

    // Reset in the middle of byte 2
    do_reset();
    expect_word(32'h5566_7788);
    send_word(32'h5566_7788);
    send_byte(8'h99, 1'b1);
    rx_i = 1'b0;
    wait_cycles(CPB);
    rx_i = 1'b1;
    wait_cycles(3 * CPB);
    rst_n = 1'b0;
    wait_cycles(2);
    check("t6_rst_valid", bus.valid_o, 0);
    check("t6_rst_data", bus.data_o, 0);
    check("t6_rst_cnt", dbg_sample_cnt, 0);
    check("t6_rst_state", dbg_state, RX_IDLE);
    rst_n = 1'b1;
    exp_cnt = 0;
    wait_cycles(2);
    expect_word(32'hCAFE_F00D);
    send_word(32'hCAFE_F00D);
    wait_cycles(5);
    check("t6_cnt", dbg_sample_cnt, 1);

    // Bounded drain of anything still expected
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) wait_cycles(1);
    check("final_drain", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
